// File: rtl/program_memory_scheduler_pkg.sv
// Shared state encodings and address-map constants for the program memory scheduler.
package program_memory_scheduler_pkg;

  localparam logic [1:0] PMS_RUN   = 2'd0;
  localparam logic [1:0] PMS_LOAD  = 2'd1;
  localparam logic [1:0] PMS_DRAIN = 2'd2;
  localparam logic [1:0] PMS_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = PMS_RUN,
    ST_LOAD  = PMS_LOAD,
    ST_DRAIN = PMS_DRAIN,
    ST_DONE  = PMS_DONE
  } pms_state_e;

  // Byte address that maps onto program memory word 0.
  localparam logic [31:0] PMS_TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/pm_fetch_decode.sv
// Translates a CPU byte fetch address into a RAM word index and flags
// misaligned or out-of-range fetches.
module pm_fetch_decode
  import program_memory_scheduler_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    ADDR_BITS    = 5,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(PMS_TEXT_BASE)
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [ADDR_BITS-1:0]  word_idx_o,
  output logic                  fault_o
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] word_full;

  // Full-width word offset is kept so the range check sees bits above ADDR_BITS.
  always_comb begin
    word_full  = (pc_i - TEXT_BASE) >> 2;
    word_idx_o = word_full[ADDR_BITS-1:0];
    fault_o    = (pc_i[1:0] != 2'b00) || (pc_i < TEXT_BASE) || (word_full >= DEPTH_W);
  end

endmodule

// File: rtl/program_memory_scheduler.sv
// Arbitrates the single program-memory port between CPU fetch and the boot loader.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | fetch owns the port, CPU runs, ld_start opens a new load
//   LOAD  | CPU stalled, loader words written sequentially from word 0
//   DRAIN | last registered write lands in RAM
//   DONE  | CPU still stalled, restart pulse scheduled for first RUN cycle
module program_memory_scheduler
  import program_memory_scheduler_pkg::*;
#(
  parameter int                    MEMORY_DEPTH  = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_BITS     = 5,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE     = DATA_WIDTH'(PMS_TEXT_BASE),
  parameter bit                    BOOT_ON_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cpu_pc,
  output logic [DATA_WIDTH-1:0] cpu_instruction,
  output logic                  cpu_stall,
  output logic                  cpu_restart,
  output logic                  pc_fault,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  load_error,
  output logic [ADDR_BITS:0]    word_count,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(MEMORY_DEPTH);
  localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS+1)'(1);

  pms_state_e            state_q, state_d;
  logic [ADDR_BITS:0]    word_count_q, word_count_d;
  logic                  load_error_q, load_error_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_BITS-1:0]  wr_idx_q, wr_idx_d;
  logic                  restart_q, restart_d;

  logic [ADDR_BITS-1:0]  fetch_idx;
  logic                  fetch_fault;
  logic                  in_run;
  logic                  can_accept;

  pm_fetch_decode #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .ADDR_BITS   (ADDR_BITS),
    .TEXT_BASE   (TEXT_BASE)
  ) u_fetch_decode (
    .pc_i      (cpu_pc),
    .word_idx_o(fetch_idx),
    .fault_o   (fetch_fault)
  );

  // State, counter and registered write port; memory contents are never touched here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT_ON_RESET ? ST_LOAD : ST_RUN;
      word_count_q <= '0;
      load_error_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      wr_idx_q     <= '0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      load_error_q <= load_error_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_idx_q     <= wr_idx_d;
      restart_q    <= restart_d;
    end
  end

  // Next-state logic plus the loader handshake and CPU stall.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    load_error_d = load_error_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wr_idx_d     = wr_idx_q;
    restart_d    = 1'b0;
    can_accept   = 1'b0;
    cpu_stall    = 1'b1;
    case (state_q)
      ST_RUN: begin
        cpu_stall = 1'b0;
        if (ld_start) begin
          state_d      = ST_LOAD;
          word_count_d = '0;
          load_error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        can_accept = (word_count_q < DEPTH_CNT);
        if (ld_valid && can_accept) begin
          mem_we_d     = 1'b1;
          mem_wdata_d  = ld_data;
          wr_idx_d     = word_count_q[ADDR_BITS-1:0];
          word_count_d = word_count_q + CNT_ONE;
          if (ld_last) begin
            state_d = ST_DRAIN;
          end
        end else if (ld_valid && (word_count_q == DEPTH_CNT)) begin
          // Image is larger than the memory: flag it and stop taking words.
          load_error_d = 1'b1;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        restart_d = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Port muxing: a pending write always wins the address so the RAM sees a stable index.
  always_comb begin
    in_run          = (state_q == ST_RUN);
    pc_fault        = in_run && fetch_fault;
    cpu_instruction = (in_run && !fetch_fault) ? mem_rdata : '0;
    mem_addr        = (in_run && !mem_we_q) ? fetch_idx : wr_idx_q;
  end

  assign ld_ready    = can_accept;
  assign cpu_restart = restart_q;
  assign load_error  = load_error_q;
  assign word_count  = word_count_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
